// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-ported register file with per-register pending scoreboard.
//            Optional write-to-read forwarding is enabled by REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rpend,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa0,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd0,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic                  any_pend
);

    // Entry 0 is tied to zero in both arrays so it folds away in synthesis.
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int k = 1; k < NREGS; k++) begin
            // Port 1 is applied last so it wins a same-address conflict.
            if (we0 && (wa0 == AW'(k))) begin
                regs_d[k] = wd0;
                pend_d[k] = 1'b0;
            end
            if (we1 && (wa1 == AW'(k))) begin
                regs_d[k] = wd1;
                pend_d[k] = 1'b0;
            end
            if (flush) begin
                pend_d[k] = 1'b0;
            end
            if (rsv_en && (rsv_addr == AW'(k))) begin
                pend_d[k] = 1'b1;
            end
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd    = '0;
        rpend = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (ra[i*AW +: AW] != '0) begin
                rd[i*XLEN +: XLEN] = regs_q[ra[i*AW +: AW]];
                rpend[i]           = pend_q[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (we1 && (wa1 == ra[i*AW +: AW])) begin
                    rd[i*XLEN +: XLEN] = wd1;
                    rpend[i]           = 1'b0;
                end else if (we0 && (wa0 == ra[i*AW +: AW])) begin
                    rd[i*XLEN +: XLEN] = wd0;
                    rpend[i]           = 1'b0;
                end
`endif
            end
        end
    end

    assign any_pend = |pend_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed vector table plus randomized traffic against a
//            behavioural model of regfile_sb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    localparam int C_XLEN  = 32;
    localparam int C_NREGS = 32;
    localparam int C_NREAD = 2;
    localparam int C_AW    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] C_BYP_RD = 32'h0000_00AA;
    localparam logic        C_BYP_P  = 1'b0;
`else
    localparam logic [31:0] C_BYP_RD = 32'h0000_0000;
    localparam logic        C_BYP_P  = 1'b1;
`endif

    logic                      clk;
    logic                      reset;
    logic [C_NREAD*C_AW-1:0]   ra;
    logic [C_NREAD*C_XLEN-1:0] rd;
    logic [C_NREAD-1:0]        rpend;
    logic                      we0, we1, rsv_en, flush, any_pend;
    logic [C_AW-1:0]           wa0, wa1, rsv_addr;
    logic [C_XLEN-1:0]         wd0, wd1;

    regfile_sb #(
        .XLEN (C_XLEN),
        .NREGS(C_NREGS),
        .NREAD(C_NREAD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ra      (ra),
        .rd      (rd),
        .rpend   (rpend),
        .we0     (we0),
        .we1     (we1),
        .wa0     (wa0),
        .wa1     (wa1),
        .wd0     (wd0),
        .wd1     (wd1),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .flush   (flush),
        .any_pend(any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we0, we1, rsv, fl;
        logic [4:0]  wa0, wa1, rsa, ra0, ra1;
        logic [31:0] wd0, wd1;
        logic [31:0] e_rd;
        logic        e_p, e_any;
    } vec_t;

    vec_t tbl[21];

    logic [31:0] m_mem [C_NREGS];
    logic        m_p   [C_NREGS];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic w0, input logic [4:0] a0,
                                input logic [31:0] d0, input logic w1, input logic [4:0] a1,
                                input logic [31:0] d1, input logic rsv, input logic [4:0] rsa,
                                input logic fl, input logic [4:0] r0, input logic [31:0] erd,
                                input logic ep, input logic eany);
        vec_t v;
        v.rst = rst; v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1;  v.wa1 = a1; v.wd1 = d1;
        v.rsv = rsv; v.rsa = rsa; v.fl = fl; v.ra0 = r0;
        v.ra1 = 5'(r0 + 5'd5);
        v.e_rd = erd; v.e_p = ep; v.e_any = eany;
        return v;
    endfunction

    // Spec-level next state: writes (port 1 last), then flush, writeback
    // clears, and finally reserve which overrides everything but reset.
    task automatic model_clock();
        if (reset) begin
            for (int k = 0; k < C_NREGS; k++) begin
                m_mem[k] = '0;
                m_p[k]   = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (flush) for (int k = 0; k < C_NREGS; k++) m_p[k] = 1'b0;
            if (we0) m_p[wa0] = 1'b0;
            if (we1) m_p[wa1] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_p[rsv_addr] = 1'b1;
        end
    endtask

    function automatic logic [32:0] model_read(input logic [4:0] a);
        if (a == 0) return 33'd0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) return {1'b0, wd1};
        if (we0 && wa0 == a) return {1'b0, wd0};
`endif
        return {m_p[a], m_mem[a]};
    endfunction

    task automatic check_model();
        logic [32:0] e;
        logic        any;
        for (int i = 0; i < C_NREAD; i++) begin
            e = model_read(ra[i*C_AW +: C_AW]);
            chk($sformatf("model_rd%0d[a=%0d]", i, ra[i*C_AW +: C_AW]), rd[i*C_XLEN +: C_XLEN], e[31:0]);
            chk($sformatf("model_rpend%0d[a=%0d]", i, ra[i*C_AW +: C_AW]), {31'd0, rpend[i]}, {31'd0, e[32]});
        end
        any = 1'b0;
        for (int k = 0; k < C_NREGS; k++) any |= m_p[k];
        chk("model_any_pend", {31'd0, any_pend}, {31'd0, any});
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        rsv_en = v.rsv; rsv_addr = v.rsa; flush = v.fl;
        ra = {v.ra1, v.ra0};
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        //            rst we0 wa0 wd0           we1 wa1 wd1    rsv rsa fl ra0 e_rd          e_p e_any
        tbl[0]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 0,  32'h0,        0, 0);
        tbl[1]  = mk(0, 1, 3,  32'hDEADBEEF, 0, 0, 32'h0,  0, 0,  0, 31, 32'h0,        0, 0);
        tbl[2]  = mk(0, 1, 0,  32'h1234,     0, 0, 32'h0,  0, 0,  0, 3,  32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 1, 7,  32'h1,        1, 7, 32'h2,  0, 0,  0, 0,  32'h0,        0, 0);
        tbl[4]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 9,  0, 7,  32'h2,        0, 0);
        tbl[5]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 9,  32'h0,        1, 1);
        tbl[6]  = mk(0, 0, 0,  32'h0,        1, 9, 32'h99, 0, 0,  0, 7,  32'h2,        0, 1);
        tbl[7]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 9,  32'h99,       0, 0);
        tbl[8]  = mk(0, 1, 9,  32'h55,       0, 0, 32'h0,  1, 9,  0, 7,  32'h2,        0, 0);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 4, 32'h44, 1, 4,  0, 9,  32'h55,       1, 1);
        tbl[10] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 6,  0, 7,  32'h2,        0, 1);
        tbl[11] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  1, 4,  32'h44,       1, 1);
        tbl[12] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 6,  32'h0,        0, 0);
        tbl[13] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 4,  1, 4,  32'h44,       0, 0);
        tbl[14] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 12, 0, 4,  32'h44,       1, 1);
        tbl[15] = mk(0, 1, 12, 32'hAA,       0, 0, 32'h0,  0, 0,  0, 12, C_BYP_RD,     C_BYP_P, 1);
        tbl[16] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  1, 12, 32'hAA,       0, 1);
        tbl[17] = mk(0, 1, 2,  32'h22,       0, 0, 32'h0,  1, 2,  0, 9,  32'h55,       0, 0);
        tbl[18] = mk(1, 1, 2,  32'h77,       0, 0, 32'h0,  1, 2,  0, 2,  32'h22,       1, 1);
        tbl[19] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 2,  32'h0,        0, 0);
        tbl[20] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 3,  32'h0,        0, 0);

        reset = 1'b1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0; ra = '0;
        @(posedge clk);
        model_clock();
        #1;

        for (int r = 0; r < 21; r++) begin
            apply(tbl[r]);
            @(negedge clk);
            chk($sformatf("row%0d_rd", r), rd[31:0], tbl[r].e_rd);
            chk($sformatf("row%0d_rpend", r), {31'd0, rpend[0]}, {31'd0, tbl[r].e_p});
            chk($sformatf("row%0d_any_pend", r), {31'd0, any_pend}, {31'd0, tbl[r].e_any});
            check_model();
            @(posedge clk);
            model_clock();
            #1;
        end

        for (int c = 0; c < 500; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            we0      = 1'($urandom_range(0, 1));
            we1      = 1'($urandom_range(0, 1));
            wa0      = rand_addr();
            wa1      = rand_addr();
            wd0      = $urandom;
            wd1      = $urandom;
            rsv_en   = ($urandom_range(0, 2) != 0);
            rsv_addr = rand_addr();
            flush    = ($urandom_range(0, 15) == 0);
            ra       = {rand_addr(), rand_addr()};
            @(negedge clk);
            check_model();
            @(posedge clk);
            model_clock();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
